// File: rtl/vga_genlock_pkg.sv
// Shared genlock definitions: FSM state codes and default timing constants.
package vga_genlock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SEARCH  = 2'd1;
    localparam state_t ST_MEASURE = 2'd2;
    localparam state_t ST_LOCKED  = 2'd3;

    localparam int unsigned GENLOCK_CNT_W      = 20;
    localparam int unsigned GENLOCK_MIN_PERIOD = 400000;
    localparam int unsigned GENLOCK_MAX_PERIOD = 520000;
    localparam int unsigned GENLOCK_LOCK_COUNT = 4;

endpackage

// File: rtl/vga_genlock_if.sv
// Bundle of the genlock control and status signals seen by the VGA timing side.
interface vga_genlock_if
    import vga_genlock_pkg::*;
#(
    parameter int unsigned CNT_W = GENLOCK_CNT_W
);
    logic             trs_vsync;
    logic             enable;
    logic [CNT_W-1:0] offset;
    logic             genlock;
    logic             locked;
    logic             lost;

    modport master (
        output trs_vsync, enable, offset,
        input  genlock, locked, lost
    );

    modport slave (
        input  trs_vsync, enable, offset,
        output genlock, locked, lost
    );
endinterface

// File: rtl/vga_genlock_sync_edge.sv
// Two-flop synchroniser for the TRS vsync plus a registered rising-edge detector.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_det
);
    logic       rx_meta;
    logic       rx_sync;
    logic       rx_prev;
    logic [2:0] fill;

    // fill gates detection until rx_prev holds a real sample, so a line that
    // is already high when reset lifts does not look like a fresh edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b0;
            rx_sync  <= 1'b0;
            rx_prev  <= 1'b0;
            fill     <= '0;
            edge_det <= 1'b0;
        end else begin
            rx_meta  <= din;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            fill     <= {fill[1:0], 1'b1};
            edge_det <= rx_sync & ~rx_prev & fill[2];
        end
    end
endmodule

// File: rtl/vga_genlock.sv
// Locks VGA timing to the TRS-80 vsync: qualifies the frame period, then emits a
// delayed one-cycle genlock pulse per good frame.
module vga_genlock
    import vga_genlock_pkg::*;
#(
    parameter int unsigned CNT_W      = GENLOCK_CNT_W,
    parameter int unsigned MIN_PERIOD = GENLOCK_MIN_PERIOD,
    parameter int unsigned MAX_PERIOD = GENLOCK_MAX_PERIOD,
    parameter int unsigned LOCK_COUNT = GENLOCK_LOCK_COUNT
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             trs_vsync,
    input  logic             enable,
    input  logic [CNT_W-1:0] offset,
    output logic             genlock,
    output logic             locked,
    output logic             lost
);
    localparam int unsigned      GOOD_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GOOD_W-1:0] LOCK_N = GOOD_W'(LOCK_COUNT);

    logic              edge_det;
    logic [CNT_W-1:0]  period;
    state_t            state;
    state_t            state_nxt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_nxt;
    logic [GOOD_W-1:0] good_inc;
    logic [CNT_W-1:0]  dly;
    logic              dly_act;
    logic              in_win;
    logic              overrun;
    logic              load;
    logic              cancel;

    sync_edge u_sync_edge (
        .clk      (vga_clk),
        .rst_n    (rst_n),
        .din      (trs_vsync),
        .edge_det (edge_det)
    );

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
        end else if (edge_det) begin
            period <= CNT_ONE;
        end else if (period != '1) begin
            period <= period + 1'b1;
        end
    end

    assign in_win   = (period >= MIN_P) && (period <= MAX_P);
    assign overrun  = (period > MAX_P);
    assign good_inc = good + 1'b1;
    assign locked   = (state == ST_LOCKED);

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        load      = 1'b0;
        cancel    = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            good_nxt  = '0;
            cancel    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_SEARCH;
                ST_SEARCH: begin
                    if (edge_det) begin
                        state_nxt = ST_MEASURE;
                        good_nxt  = '0;
                    end
                end
                ST_MEASURE: begin
                    if (edge_det) begin
                        if (in_win) begin
                            good_nxt = good_inc;
                            if (good_inc == LOCK_N) begin
                                state_nxt = ST_LOCKED;
                                load      = 1'b1;
                            end
                        end else begin
                            good_nxt = '0;
                        end
                    end else if (overrun) begin
                        state_nxt = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (edge_det && in_win) begin
                        load = 1'b1;
                    end else if (edge_det || overrun) begin
                        state_nxt = ST_SEARCH;
                        cancel    = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // A new edge always reloads or cancels the delay, so a pending pulse can
    // never land on or after the following edge.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            good    <= '0;
            lost    <= 1'b0;
            genlock <= 1'b0;
            dly     <= '0;
            dly_act <= 1'b0;
        end else begin
            state   <= state_nxt;
            good    <= good_nxt;
            lost    <= (state == ST_LOCKED) && (state_nxt != ST_LOCKED);
            genlock <= 1'b0;
            if (cancel) begin
                dly_act <= 1'b0;
            end else if (load) begin
                if (offset == '0) begin
                    genlock <= 1'b1;
                    dly_act <= 1'b0;
                end else begin
                    dly     <= offset - 1'b1;
                    dly_act <= 1'b1;
                end
            end else if (dly_act) begin
                if (dly == '0) begin
                    genlock <= 1'b1;
                    dly_act <= 1'b0;
                end else begin
                    dly <= dly - 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/vga_genlock.md
VGA_GENLOCK -- requirements
Module: vga_genlock

Interface
REQ-001 SHALL have parameter CNT_W, default 20, meaning the width of the period and offset counters.
REQ-002 SHALL have parameter MIN_PERIOD, default 400000, meaning the shortest acceptable TRS frame period in vga_clk cycles.
REQ-003 SHALL have parameter MAX_PERIOD, default 520000, meaning the longest acceptable TRS frame period in vga_clk cycles.
REQ-004 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive in-window periods required to lock.
REQ-005 SHALL have port vga_clk, input, 1 bit: the 25 MHz VGA pixel clock. The block uses one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port trs_vsync, input, 1 bit: raw TRS-80 vertical sync, asynchronous to vga_clk, active-high.
REQ-008 SHALL have port enable, input, 1 bit: genlock enable.
REQ-009 SHALL have port offset, input, CNT_W bits: delay in cycles from the detected TRS vsync edge to the genlock pulse.
REQ-010 SHALL have port genlock, output, 1 bit: one-cycle pulse that restarts the VGA timing counters.
REQ-011 SHALL have port locked, output, 1 bit: high while in the LOCKED state.
REQ-012 SHALL have port lost, output, 1 bit: one-cycle pulse on exit from LOCKED.

Function
REQ-013 SHALL synchronise trs_vsync through two flip-flops, then register it once more for edge detection; edge_det is high for one cycle on a synchronised 0->1 transition, 3 cycles after the raw edge.
REQ-014 SHALL keep a period counter, CNT_W bits, that clears to 1 on edge_det, otherwise increments, and saturates at all-ones.
REQ-015 SHALL have states IDLE, SEARCH, MEASURE, LOCKED.
REQ-016 IDLE SHALL transition to SEARCH when enable=1; enable=0 in any state SHALL force IDLE next cycle, clear the good count and cancel any pending pulse.
REQ-017 SEARCH SHALL transition to MEASURE on the first edge_det and clear the good count.
REQ-018 MEASURE, on each edge_det:
- Period in [MIN_PERIOD, MAX_PERIOD] (both inclusive) increments the good count.
- When the incremented count equals LOCK_COUNT, transition to LOCKED.
- A period outside the window resets the good count to 0 and stays in MEASURE.
REQ-019 MEASURE, on period counter > MAX_PERIOD with no edge, SHALL transition to SEARCH.
REQ-020 LOCKED, on each in-window edge_det, SHALL latch offset and load the delay counter; genlock SHALL assert exactly offset+1 cycles after edge_det.
- offset=0 gives a pulse on the cycle after edge_det.
REQ-021 LOCKED, on an out-of-window edge_det or period counter > MAX_PERIOD, SHALL pulse lost, cancel any pending pulse, and transition to SEARCH.
REQ-022 An in-window edge_det while a delay is pending SHALL restart the delay with the newly sampled offset; the earlier pulse is dropped.
REQ-023 The delay SHALL NOT span a following edge; an offset ≥ the period therefore never produces a pulse.
REQ-024 genlock SHALL never be high for two consecutive cycles and SHALL be high only in LOCKED.
REQ-025 The transition into LOCKED SHALL itself schedule a pulse for that edge.

Reset
REQ-026 While rst_n=0:
- State is IDLE.
- genlock=0, locked=0, lost=0.
- Synchroniser flops, edge register and counters are 0; delay is inactive.
REQ-027 Reset mid-delay SHALL suppress the pending pulse.
REQ-028 After rst_n rises, the first edge SHALL be taken from a fresh 0 history, so a vsync that is already high produces no edge.

Structure
REQ-029 Package vga_genlock_pkg SHALL hold the state enumeration, CNT_W, and the default MIN_PERIOD, MAX_PERIOD and LOCK_COUNT constants.
REQ-030 Sub-module sync_edge SHALL implement the two-flip-flop synchroniser plus rising-edge detector; all other logic is flat.

Verification
REQ-031 enable=1, offset=0, vsync edges every 416667 cycles: locked rises on the 5th edge (4th good period); genlock pulses 4 cycles after each raw edge from the 5th edge on.
REQ-032 Locked, offset=1000: genlock rises exactly 1004 cycles after each raw edge.
REQ-033 Locked, vsync stopped: lost pulses and locked falls at period counter = 520001; state returns to SEARCH.
REQ-034 MEASURE with period sequence 416667, 300000, 416667×4: the good count resets at the 300000 period; lock is reached only after 4 further good periods.
REQ-035 Locked, offset=200000, with a second edge 100000 cycles after the first: lost pulses, no genlock is emitted, and locked=0.
REQ-036 rst_n low for 3 cycles during a pending delay: no genlock pulse, all outputs 0; relock needs LOCK_COUNT new good periods.
